// File: rtl/fifo_flex_pkg.sv
// Shared helpers for fifo_flex: count width, wrapping pointer increment, default thresholds.
// Pure constants/functions; no state, no latency.
package fifo_pkg;

  localparam int DEF_WIDTH    = 64;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AE_LEVEL = 1;

  // almost_full defaults to one below full
  function automatic int def_af_level(input int depth);
    return depth - 1;
  endfunction

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Wrap explicitly at depth-1 so non power-of-two depths work
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_flex_if.sv
// Write/read handshake, status and error bundle of fifo_flex.
// master = producer/consumer side, slave = the FIFO.
interface fifo_flex_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int CW = count_w(DEPTH);

  logic             w_valid;
  logic [WIDTH-1:0] data_in;
  logic             r_ready;
  logic             err_clr;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             fifo_full;
  logic             fifo_empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    fifo_count;
  logic             overflow;
  logic             underflow;

  modport master (
    output w_valid, data_in, r_ready, err_clr,
    input  data_out, rd_valid, fifo_full, fifo_empty, almost_full,
           almost_empty, fifo_count, overflow, underflow
  );

  modport slave (
    input  w_valid, data_in, r_ready, err_clr,
    output data_out, rd_valid, fifo_full, fifo_empty, almost_full,
           almost_empty, fifo_count, overflow, underflow
  );

endinterface

// File: rtl/fifo_flex_ram.sv
// WIDTH x DEPTH storage: one synchronous write port, one asynchronous read port.
// Write visible on the read port the cycle after the write edge; storage is never reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flex.sv
// Synchronous FIFO, any depth, with count, thresholds and sticky errors; full drops writes, empty refuses reads.
// Read latency 1 (registered data_out, pulsed rd_valid), or 0 with FIFO_FWFT_EN (head word shown, rd_valid = !empty).
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = def_af_level(DEPTH),
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic        clk,
  input  logic        rst,
  fifo_flex_if.slave  bus
);

  localparam int CW = count_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full, empty;
  logic             wr_en, rd_en;
  logic [WIDTH-1:0] ram_rdata;

  // Every flag and both accept decisions use the start-of-cycle count
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_en = bus.w_valid && !full;
  assign rd_en = bus.r_ready && !empty;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_en) begin
      wr_ptr_d = PW'(ptr_inc(int'(wr_ptr_q), DEPTH));
    end
    if (rd_en) begin
      rd_ptr_d = PW'(ptr_inc(int'(rd_ptr_q), DEPTH));
    end

    if (wr_en && !rd_en) begin
      count_d = count_q + CW'(1);
    end else if (!wr_en && rd_en) begin
      count_d = count_q - CW'(1);
    end

    // A new error event beats a coincident clear
    if (bus.w_valid && full) begin
      overflow_d = 1'b1;
    end else if (bus.err_clr) begin
      overflow_d = 1'b0;
    end
    if (bus.r_ready && empty) begin
      underflow_d = 1'b1;
    end else if (bus.err_clr) begin
      underflow_d = 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Masked while empty so the unwritten/stale head never leaks out
  assign bus.data_out = empty ? '0 : ram_rdata;
  assign bus.rd_valid = !empty;
`else
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             rd_valid_q, rd_valid_d;

  always_comb begin
    data_out_d = rd_en ? ram_rdata : data_out_q;
    rd_valid_d = rd_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      data_out_q  <= data_out_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.fifo_full    = full;
  assign bus.fifo_empty   = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.fifo_count   = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: DEPTH=5 instance checked by a reference queue every cycle, DEPTH=1 instance by directed checks.
module tb_fifo_flex;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  initial forever #5 clk = ~clk;

  fifo_flex_if #(.WIDTH(8), .DEPTH(5)) a ();
  fifo_flex_if #(.WIDTH(8), .DEPTH(1)) b ();

  fifo_flex #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  fifo_flex #(.WIDTH(8), .DEPTH(1), .AF_LEVEL(1), .AE_LEVEL(0)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_a(input bit w, input logic [7:0] d, input bit r, input bit c);
    a.w_valid = w;
    a.data_in = d;
    a.r_ready = r;
    a.err_clr = c;
  endtask

  task automatic drive_b(input bit w, input logic [7:0] d, input bit r, input bit c);
    b.w_valid = w;
    b.data_in = d;
    b.r_ready = r;
    b.err_clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the DEPTH=5 instance, updated from the inputs at each edge
  int         m_cnt = 0;
  logic [7:0] m_q[$];
  logic [7:0] m_out[$];
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;
  bit         m_rdv = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    bit we, re;
    if (rst) begin
      m_q.delete();
      m_out.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_rdv = 1'b0;
    end else begin
      we = a.w_valid && (m_cnt != 5);
      re = a.r_ready && (m_cnt != 0);
      if (a.w_valid && m_cnt == 5) m_ovf = 1'b1;
      else if (a.err_clr)          m_ovf = 1'b0;
      if (a.r_ready && m_cnt == 0) m_udf = 1'b1;
      else if (a.err_clr)          m_udf = 1'b0;
      m_rdv = re;
      if (re) begin
`ifdef FIFO_FWFT_EN
        void'(m_q.pop_front());
`else
        m_out.push_back(m_q.pop_front());
`endif
      end
      if (we) m_q.push_back(a.data_in);
      m_cnt = m_q.size();
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge
  always @(negedge clk) begin
    check("count",        64'(a.fifo_count),   64'(m_cnt));
    check("empty",        64'(a.fifo_empty),   64'(m_cnt == 0));
    check("full",         64'(a.fifo_full),    64'(m_cnt == 5));
    check("almost_full",  64'(a.almost_full),  64'(m_cnt >= 4));
    check("almost_empty", 64'(a.almost_empty), 64'(m_cnt <= 1));
    check("overflow",     64'(a.overflow),     64'(m_ovf));
    check("underflow",    64'(a.underflow),    64'(m_udf));
`ifdef FIFO_FWFT_EN
    check("rd_valid", 64'(a.rd_valid), 64'(m_cnt != 0));
    if (a.rd_valid && m_q.size() != 0) check("head", 64'(a.data_out), 64'(m_q[0]));
`else
    check("rd_valid", 64'(a.rd_valid), 64'(m_rdv));
    if (a.rd_valid) begin
      if (m_out.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL data: rd_valid with no expected word, got %0h", a.data_out);
      end else begin
        check("data", 64'(a.data_out), 64'(m_out.pop_front()));
      end
    end
`endif
  end

  logic [7:0] vec [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};

  initial begin
    drive_a(0, 8'h00, 0, 0);
    drive_b(0, 8'h00, 0, 0);
    #2;
    check("rst count",     64'(a.fifo_count),   64'd0);
    check("rst empty",     64'(a.fifo_empty),   64'd1);
    check("rst ae",        64'(a.almost_empty), 64'd1);
    check("rst af",        64'(a.almost_full),  64'd0);
    check("rst full",      64'(a.fifo_full),    64'd0);
    check("rst rd_valid",  64'(a.rd_valid),     64'd0);
    check("rst data_out",  64'(a.data_out),     64'd0);
    check("rst errors",    64'({a.overflow, a.underflow}), 64'd0);
    #10 rst = 1'b0;
    tick();
    tick();

    // Fill DEPTH=5 with A0..A4
    for (int i = 0; i < 5; i++) begin
      drive_a(1, vec[i], 0, 0);
      tick();
      check("fill count", 64'(a.fifo_count), 64'(i + 1));
      check("fill af",    64'(a.almost_full), 64'(i >= 3));
      check("fill full",  64'(a.fifo_full),   64'(i == 4));
      check("fill ae",    64'(a.almost_empty), 64'(i == 0));
    end
    drive_a(1, 8'hFF, 0, 0);
    tick();
    check("overflow set", 64'(a.overflow),   64'd1);
    check("ovf count",    64'(a.fifo_count), 64'd5);

    // Drain in order; 0xFF must not appear
    for (int i = 0; i < 5; i++) begin
`ifdef FIFO_FWFT_EN
      check("fwft head", 64'(a.data_out), 64'(vec[i]));
`endif
      drive_a(0, 8'h00, 1, 0);
      tick();
`ifndef FIFO_FWFT_EN
      check("read data",  64'(a.data_out), 64'(vec[i]));
      check("read pulse", 64'(a.rd_valid), 64'd1);
`endif
    end
    drive_a(0, 8'h00, 1, 0);
    tick();
    check("underflow set",  64'(a.underflow), 64'd1);
    check("ovf still held", 64'(a.overflow),  64'd1);
`ifndef FIFO_FWFT_EN
    check("no pulse on refused read", 64'(a.rd_valid), 64'd0);
    check("data_out held",            64'(a.data_out), 64'hA4);
`endif
    drive_a(0, 8'h00, 0, 1);
    tick();
    check("err_clr", 64'({a.overflow, a.underflow}), 64'd0);

    // Fill 3 then 10 simultaneous write/read cycles: pointers wrap twice
    for (int i = 0; i < 3; i++) begin
      drive_a(1, 8'hB0 + 8'(i), 0, 0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive_a(1, 8'hC0 + 8'(i), 1, 0);
      tick();
      check("steady count", 64'(a.fifo_count), 64'd3);
    end
`ifdef FIFO_FWFT_EN
    drive_a(0, 8'h00, 0, 0);
    tick();
    check("wrap head", 64'(a.data_out), 64'hC7);
`endif
    for (int i = 0; i < 3; i++) begin
      drive_a(0, 8'h00, 1, 0);
      tick();
    end
`ifndef FIFO_FWFT_EN
    check("wrap last", 64'(a.data_out), 64'hC9);
`endif

    // Error event coinciding with err_clr: set wins
    drive_a(0, 8'h00, 1, 1);
    tick();
    check("set beats clr", 64'(a.underflow), 64'd1);
    drive_a(0, 8'h00, 0, 1);
    tick();
    check("clr alone", 64'(a.underflow), 64'd0);
    drive_a(0, 8'h00, 0, 0);

    // DEPTH=1 directed sequence
    drive_b(1, 8'h01, 0, 0);
    tick();
    check("d1 count", 64'(b.fifo_count), 64'd1);
    check("d1 full",  64'(b.fifo_full),  64'd1);
    check("d1 empty", 64'(b.fifo_empty), 64'd0);
`ifdef FIFO_FWFT_EN
    check("d1 head 1", 64'(b.data_out), 64'h01);
`endif
    drive_b(0, 8'h00, 1, 0);
    tick();
`ifndef FIFO_FWFT_EN
    check("d1 data 1", 64'(b.data_out), 64'h01);
`endif
    check("d1 empty after read", 64'(b.fifo_empty), 64'd1);
    drive_b(1, 8'h02, 1, 0);
    tick();
    check("d1 wr+rd count", 64'(b.fifo_count), 64'd1);
    check("d1 underflow",   64'(b.underflow),  64'd1);
`ifdef FIFO_FWFT_EN
    check("d1 head 2", 64'(b.data_out), 64'h02);
`else
    check("d1 refused read", 64'(b.rd_valid), 64'd0);
`endif
    drive_b(0, 8'h00, 1, 0);
    tick();
`ifndef FIFO_FWFT_EN
    check("d1 data 2",  64'(b.data_out), 64'h02);
    check("d1 pulse 2", 64'(b.rd_valid), 64'd1);
`endif
    check("d1 final empty", 64'(b.fifo_empty), 64'd1);
    drive_b(0, 8'h00, 0, 1);
    tick();
    check("d1 clr", 64'(b.underflow), 64'd0);
    drive_b(0, 8'h00, 0, 0);

    // Random push/pop against the model
    for (int i = 0; i < 3000; i++) begin
      drive_a(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
      tick();
    end

    // Asynchronous reset mid-burst
    drive_a(0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive_a(1, 8'hD0 + 8'(i), 0, 0);
      tick();
    end
    #1 rst = 1'b1;
    #1;
    check("async rst count", 64'(a.fifo_count), 64'd0);
    check("async rst empty", 64'(a.fifo_empty), 64'd1);
    drive_a(0, 8'h00, 0, 0);
    #1 rst = 1'b0;
    tick();
    drive_a(1, 8'hE0, 0, 0);
    tick();
    check("post rst count", 64'(a.fifo_count), 64'd1);
    drive_a(0, 8'h00, 1, 0);
    tick();
    drive_a(0, 8'h00, 0, 0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
